// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the shared data-memory/MMIO port, with a
// bounded burst length. Optional owner lock is enabled by DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [2:0]    m0_op,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [2:0]    m1_op,
`ifdef DMEM_ARB_LOCK_EN
  input  logic          m0_lock,
  input  logic          m1_lock,
`endif
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_op,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);

  // Encoding doubles as the owner output.
  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_e;

  state_e        state_q, state_d;
  logic          prio_q, prio_d;   // 0 = M0 wins an idle tie
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rtag_q, rtag_d;   // {m1 read pending, m0 read pending}

  logic          sel1, own_any, req_own, req_oth, grant, own_lock;
  logic [CW-1:0] cnt_base, cnt_nxt;
  state_e        oth_state;

`ifdef DMEM_ARB_LOCK_EN
  logic lock_q, lock_d;
  always_ff @(posedge clock or negedge reset)
    if (!reset) lock_q <= 1'b0;
    else        lock_q <= lock_d;
`endif

  always_comb begin
    sel1      = (state_q == OWN1);
    own_any   = (state_q == OWN0) || (state_q == OWN1);
    req_own   = sel1 ? m1_req : m0_req;
    req_oth   = sel1 ? m0_req : m1_req;
    oth_state = sel1 ? OWN0 : OWN1;
    grant     = own_any && req_own;
`ifdef DMEM_ARB_LOCK_EN
    own_lock  = own_any && (sel1 ? m1_lock : m0_lock);
    lock_d    = own_lock;
    // Releasing the lock restarts the burst count from zero.
    cnt_base  = (lock_q && !own_lock) ? '0 : cnt_q;
`else
    own_lock  = 1'b0;
    cnt_base  = cnt_q;
`endif
    cnt_nxt   = (grant && cnt_base != CMAX) ? cnt_base + CW'(1) : cnt_base;

    m0_gnt    = grant && !sel1;
    m1_gnt    = grant && sel1;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_op    = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (grant) begin
      mem_addr  = sel1 ? m1_addr  : m0_addr;
      mem_wdata = sel1 ? m1_wdata : m0_wdata;
      mem_op    = sel1 ? m1_op    : m0_op;
      mem_we    = sel1 ? m1_we    : m0_we;
      mem_re    = !mem_we;
    end

    state_d = state_q;
    cnt_d   = cnt_nxt;
    prio_d  = grant ? !sel1 : prio_q;
    rtag_d  = {m1_gnt && !m1_we, m0_gnt && !m0_we};

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0_req && m1_req) state_d = prio_q ? OWN1 : OWN0;
        else if (m0_req)      state_d = OWN0;
        else if (m1_req)      state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (own_lock) begin
          state_d = state_q;
        end else if (req_oth && (!req_own || cnt_nxt == CMAX)) begin
          state_d = oth_state;
          cnt_d   = '0;
        end else if (!req_own && !req_oth) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      rtag_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      rtag_q  <= rtag_d;
    end
  end

  assign owner     = state_q;
  assign m0_rvalid = rtag_q[0];
  assign m1_rvalid = rtag_q[1];
  assign m0_rdata  = rtag_q[0] ? mem_rdata : '0;
  assign m1_rdata  = rtag_q[1] ? mem_rdata : '0;

endmodule
